// File: rtl/maxpool2d_window_sched_if.sv
// Read-request bus between the pooling window scheduler and the feature-map buffer.
//   rd_valid  : read request valid (scheduler -> buffer)
//   rd_ready  : buffer accepts the request (buffer -> scheduler)
//   rd_addr   : read address of the current tap
//   win_first : current tap is the first of its window
//   win_last  : current tap is the last of its window
//   out_idx   : output element index of the current window
interface maxpool2d_window_sched_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              win_first;
    logic              win_last;
    logic [ADDR_W-1:0] out_idx;

    modport master (
        output rd_valid,
        output rd_addr,
        output win_first,
        output win_last,
        output out_idx,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_addr,
        input  win_first,
        input  win_last,
        input  out_idx,
        output rd_ready
    );
endinterface

// File: rtl/maxpool2d_window_sched.sv
// 2D max-pooling window scheduler: walks every output position (oh, ow) and every
// kernel tap (kh, kw) of one feature map and issues one buffer read per tap.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : request a pass (IDLE only); base_addr latched on acceptance
//   abort      : cancel the pass in progress (RUN only)
//   busy       : high while the pass is running
//   done       : one-cycle pulse on normal completion
//   rd         : read-request bus (master side)
module maxpool2d_window_sched #(
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned K      = 2,
    parameter int unsigned STRIDE = 2,
    parameter int unsigned ADDR_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [ADDR_W-1:0]          base_addr,
    output logic                       busy,
    output logic                       done,
    maxpool2d_window_sched_if.master   rd
);

    localparam int unsigned OW    = (IMG_W - K) / STRIDE + 1;
    localparam int unsigned OH    = (IMG_H - K) / STRIDE + 1;
    localparam int unsigned KC_W  = (K  > 1) ? $clog2(K)  : 1;
    localparam int unsigned OWC_W = (OW > 1) ? $clog2(OW) : 1;
    localparam int unsigned OHC_W = (OH > 1) ? $clog2(OH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_base;
    logic [KC_W-1:0]    r_kw;
    logic [KC_W-1:0]    r_kh;
    logic [OWC_W-1:0]   r_ow;
    logic [OHC_W-1:0]   r_oh;
    logic               r_busy;
    logic               r_done;
    logic               r_valid;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_first;
    logic               r_last;
    logic [ADDR_W-1:0]  r_idx;

    state_t             w_state_nx;
    logic [ADDR_W-1:0]  w_base_nx;
    logic [KC_W-1:0]    w_kw_nx;
    logic [KC_W-1:0]    w_kh_nx;
    logic [OWC_W-1:0]   w_ow_nx;
    logic [OHC_W-1:0]   w_oh_nx;
    logic               w_run_nx;
    logic               w_done_nx;
    logic [ADDR_W-1:0]  w_addr_nx;
    logic               w_first_nx;
    logic               w_last_nx;
    logic [ADDR_W-1:0]  w_idx_nx;
    logic [31:0]        w_row;
    logic [31:0]        w_col;
    logic [31:0]        w_sum;
    logic               w_xfer;
    logic               w_kw_max;
    logic               w_kh_max;
    logic               w_ow_max;
    logic               w_oh_max;

    assign w_xfer   = r_valid && rd.rd_ready;
    assign w_kw_max = (r_kw == KC_W'(K - 1));
    assign w_kh_max = (r_kh == KC_W'(K - 1));
    assign w_ow_max = (r_ow == OWC_W'(OW - 1));
    assign w_oh_max = (r_oh == OHC_W'(OH - 1));

    // Next state, counter walk (kw innermost, oh outermost) and next registered outputs.
    always_comb begin
        w_state_nx = r_state;
        w_base_nx  = r_base;
        w_kw_nx    = r_kw;
        w_kh_nx    = r_kh;
        w_ow_nx    = r_ow;
        w_oh_nx    = r_oh;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = S_RUN;
                    w_base_nx  = base_addr;
                    w_kw_nx    = '0;
                    w_kh_nx    = '0;
                    w_ow_nx    = '0;
                    w_oh_nx    = '0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    // Abort wins over a coincident transfer; the beat is simply dropped here.
                    w_state_nx = S_IDLE;
                    w_kw_nx    = '0;
                    w_kh_nx    = '0;
                    w_ow_nx    = '0;
                    w_oh_nx    = '0;
                end else if (w_xfer) begin
                    if (!w_kw_max) begin
                        w_kw_nx = r_kw + KC_W'(1);
                    end else begin
                        w_kw_nx = '0;
                        if (!w_kh_max) begin
                            w_kh_nx = r_kh + KC_W'(1);
                        end else begin
                            w_kh_nx = '0;
                            if (!w_ow_max) begin
                                w_ow_nx = r_ow + OWC_W'(1);
                            end else begin
                                w_ow_nx = '0;
                                if (!w_oh_max) begin
                                    w_oh_nx = r_oh + OHC_W'(1);
                                end else begin
                                    w_oh_nx    = '0;
                                    w_state_nx = S_DONE;
                                end
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        w_run_nx  = (w_state_nx == S_RUN);
        w_done_nx = (w_state_nx == S_DONE);

        // Address from the next counters, so it is already valid in the first RUN cycle.
        w_row      = 32'(w_oh_nx) * STRIDE + 32'(w_kh_nx);
        w_col      = 32'(w_ow_nx) * STRIDE + 32'(w_kw_nx);
        w_sum      = 32'(w_base_nx) + w_row * IMG_W + w_col;
        w_addr_nx  = w_run_nx ? ADDR_W'(w_sum) : '0;
        w_idx_nx   = w_run_nx ? ADDR_W'(32'(w_oh_nx) * OW + 32'(w_ow_nx)) : '0;
        w_first_nx = w_run_nx && (w_kh_nx == '0) && (w_kw_nx == '0);
        w_last_nx  = w_run_nx && (w_kh_nx == KC_W'(K - 1)) && (w_kw_nx == KC_W'(K - 1));
    end

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_kw    <= '0;
            r_kh    <= '0;
            r_ow    <= '0;
            r_oh    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_base  <= w_base_nx;
            r_kw    <= w_kw_nx;
            r_kh    <= w_kh_nx;
            r_ow    <= w_ow_nx;
            r_oh    <= w_oh_nx;
            r_busy  <= w_run_nx;
            r_done  <= w_done_nx;
            r_valid <= w_run_nx;
            r_addr  <= w_addr_nx;
            r_first <= w_first_nx;
            r_last  <= w_last_nx;
            r_idx   <= w_idx_nx;
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign rd.rd_valid  = r_valid;
    assign rd.rd_addr   = r_addr;
    assign rd.win_first = r_first;
    assign rd.win_last  = r_last;
    assign rd.out_idx   = r_idx;

endmodule

// File: tb/tb_maxpool2d_window_sched.sv
// Self-checking bench for maxpool2d_window_sched: three configurations (defaults,
// 5x5/K3/S1, 8-bit address) checked against a loop-based beat-list model.
module tb_maxpool2d_window_sched;

    typedef struct {
        int unsigned addr;
        int unsigned idx;
        bit          first;
        bit          last;
    } beat_t;

    typedef struct {
        bit          ready;
        int unsigned addr;
        int unsigned idx;
        bit          first;
        bit          last;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        g_start;
    logic        g_abort;
    logic        g_ready;
    logic [15:0] g_base;
    int          sel;

    int          n_vec = 0;
    int          n_err = 0;
    beat_t       exp_q[$];
    vec_t        tbl[12];

    always #5 clk = ~clk;

    logic a_start, b_start, c_start, a_abort, b_abort, c_abort;
    logic a_busy, b_busy, c_busy, a_done, b_done, c_done;

    assign a_start = g_start && (sel == 0);
    assign b_start = g_start && (sel == 1);
    assign c_start = g_start && (sel == 2);
    assign a_abort = g_abort && (sel == 0);
    assign b_abort = g_abort && (sel == 1);
    assign c_abort = g_abort && (sel == 2);

    maxpool2d_window_sched_if #(.ADDR_W(16)) a_if();
    maxpool2d_window_sched_if #(.ADDR_W(16)) b_if();
    maxpool2d_window_sched_if #(.ADDR_W(8))  c_if();

    assign a_if.rd_ready = g_ready;
    assign b_if.rd_ready = g_ready;
    assign c_if.rd_ready = g_ready;

    maxpool2d_window_sched #(.IMG_W(8), .IMG_H(8), .K(2), .STRIDE(2), .ADDR_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
        .base_addr(g_base), .busy(a_busy), .done(a_done), .rd(a_if)
    );
    maxpool2d_window_sched #(.IMG_W(5), .IMG_H(5), .K(3), .STRIDE(1), .ADDR_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
        .base_addr(g_base), .busy(b_busy), .done(b_done), .rd(b_if)
    );
    maxpool2d_window_sched #(.IMG_W(8), .IMG_H(8), .K(2), .STRIDE(2), .ADDR_W(8)) u_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .abort(c_abort),
        .base_addr(g_base[7:0]), .busy(c_busy), .done(c_done), .rd(c_if)
    );

    logic        m_valid, m_busy, m_done, m_first, m_last;
    int unsigned m_addr, m_idx;

    // Selected instance's outputs.
    always_comb begin
        m_valid = a_if.rd_valid;  m_busy = a_busy;  m_done = a_done;
        m_first = a_if.win_first; m_last = a_if.win_last;
        m_addr  = 32'(a_if.rd_addr); m_idx = 32'(a_if.out_idx);
        case (sel)
            1: begin
                m_valid = b_if.rd_valid;  m_busy = b_busy;  m_done = b_done;
                m_first = b_if.win_first; m_last = b_if.win_last;
                m_addr  = 32'(b_if.rd_addr); m_idx = 32'(b_if.out_idx);
            end
            2: begin
                m_valid = c_if.rd_valid;  m_busy = c_busy;  m_done = c_done;
                m_first = c_if.win_first; m_last = c_if.win_last;
                m_addr  = 32'(c_if.rd_addr); m_idx = 32'(c_if.out_idx);
            end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            if (n_err < 40)
                $display("FAIL %s (sel=%0d t=%0t): got %0d expected %0d", name, sel, $time, got, expv);
        end
    endtask

    // Expected beat list, built straight from the window/tap definition.
    task automatic gen_expected(input int s, input int unsigned base);
        int unsigned w, h, k, st, aw, ow_n, oh_n, mask;
        beat_t b;
        case (s)
            1:       begin w = 5; h = 5; k = 3; st = 1; aw = 16; end
            2:       begin w = 8; h = 8; k = 2; st = 2; aw = 8;  end
            default: begin w = 8; h = 8; k = 2; st = 2; aw = 16; end
        endcase
        mask = (32'd1 << aw) - 32'd1;
        ow_n = (w - k) / st + 1;
        oh_n = (h - k) / st + 1;
        exp_q.delete();
        for (int unsigned oh = 0; oh < oh_n; oh++)
            for (int unsigned ow = 0; ow < ow_n; ow++)
                for (int unsigned kh = 0; kh < k; kh++)
                    for (int unsigned kw = 0; kw < k; kw++) begin
                        b.addr  = (base + (oh * st + kh) * w + ow * st + kw) & mask;
                        b.idx   = oh * ow_n + ow;
                        b.first = (kh == 0) && (kw == 0);
                        b.last  = (kh == k - 1) && (kw == k - 1);
                        exp_q.push_back(b);
                    end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_valid"}, 64'(m_valid), 0);
        chk({name, "_busy"},  64'(m_busy),  0);
        chk({name, "_done"},  64'(m_done),  0);
    endtask

    // One pass from the current (IDLE) negedge: rmode 1 = random rd_ready,
    // abort_cyc > 0 aborts in that cycle, extra_start toggles start while busy.
    task automatic run_pass(input int s, input int unsigned base, input int rmode,
                            input int abort_cyc, input int extra_start);
        int    cyc;
        int    n_beats;
        bit    aborted;
        beat_t e;
        sel = s;
        gen_expected(s, base);
        n_beats = exp_q.size();
        g_base  = 16'(base);
        g_start = 1'b1;
        @(negedge clk);
        g_start = 1'b0;
        cyc     = 1;
        aborted = 1'b0;
        while (exp_q.size() > 0 && cyc < 4000) begin
            g_ready = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            g_start = (extra_start != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            g_abort = (cyc == abort_cyc);
            e = exp_q[0];
            chk("rd_valid",  64'(m_valid), 1);
            chk("busy",      64'(m_busy),  1);
            chk("done_run",  64'(m_done),  0);
            chk("rd_addr",   64'(m_addr),  64'(e.addr));
            chk("out_idx",   64'(m_idx),   64'(e.idx));
            chk("win_first", 64'(m_first), 64'(e.first));
            chk("win_last",  64'(m_last),  64'(e.last));
            if (g_ready) void'(exp_q.pop_front());
            @(negedge clk);
            cyc++;
            if (g_abort) begin
                aborted = 1'b1;
                break;
            end
        end
        g_abort = 1'b0;
        g_start = 1'b0;
        g_ready = 1'b1;
        if (aborted) begin
            chk_idle("abort");
            repeat (3) begin
                @(negedge clk);
                chk_idle("post_abort");
            end
        end else begin
            chk("beats_left", 64'(exp_q.size()), 0);
            chk("done_pulse", 64'(m_done),  1);
            chk("done_busy",  64'(m_busy),  0);
            chk("done_valid", 64'(m_valid), 0);
            if (rmode == 0) chk("done_cycle", 64'(cyc), 64'(n_beats + 1));
            @(negedge clk);
            chk_idle("after_done");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Default-config stall sequence: window 0, then beat 4 (addr 2) held 3 cycles.
        tbl[0]  = '{1'b1,  0, 0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1,  1, 0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1,  8, 0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1,  9, 0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0,  2, 1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0,  2, 1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0,  2, 1, 1'b1, 1'b0};
        tbl[7]  = '{1'b1,  2, 1, 1'b1, 1'b0};
        tbl[8]  = '{1'b1,  3, 1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 10, 1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 11, 1, 1'b0, 1'b1};
        tbl[11] = '{1'b1,  4, 2, 1'b1, 1'b0};

        rst_n   = 1'b0;
        g_start = 1'b0;
        g_abort = 1'b0;
        g_ready = 1'b1;
        g_base  = 16'h0;
        sel     = 0;
        repeat (3) @(negedge clk);

        // Reset values on every instance.
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk_idle("reset");
            chk("reset_addr",  64'(m_addr),  0);
            chk("reset_idx",   64'(m_idx),   0);
            chk("reset_first", 64'(m_first), 0);
            chk("reset_last",  64'(m_last),  0);
        end
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full pass with rd_ready held high, then back-to-back start after DONE.
        run_pass(0, 0, 0, 0, 0);
        run_pass(0, 0, 0, 0, 0);

        // Stall table and tail of the same pass.
        g_base  = 16'h0;
        g_start = 1'b1;
        @(negedge clk);
        g_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            g_ready = tbl[i].ready;
            chk("tbl_valid", 64'(m_valid), 1);
            chk("tbl_done",  64'(m_done),  0);
            chk("tbl_addr",  64'(m_addr),  64'(tbl[i].addr));
            chk("tbl_idx",   64'(m_idx),   64'(tbl[i].idx));
            chk("tbl_first", 64'(m_first), 64'(tbl[i].first));
            chk("tbl_last",  64'(m_last),  64'(tbl[i].last));
            @(negedge clk);
        end
        g_ready = 1'b1;
        for (int c = 13; c <= 67; c++) begin
            chk("tail_valid", 64'(m_valid), 1);
            chk("tail_done",  64'(m_done),  0);
            if (c == 67) begin
                chk("tail_last_addr", 64'(m_addr), 63);
                chk("tail_last_idx",  64'(m_idx),  15);
                chk("tail_last_flag", 64'(m_last), 1);
            end
            @(negedge clk);
        end
        chk("stall_done_c68", 64'(m_done), 1);
        chk("stall_busy_c68", 64'(m_busy), 0);
        @(negedge clk);
        chk_idle("stall_after_done");

        // 5x5, K=3, stride 1 (overlapping windows).
        run_pass(1, 0, 0, 0, 0);
        run_pass(1, $urandom_range(0, 65535), 1, 0, 0);

        // 8-bit address wrap.
        run_pass(2, 32'hFC, 0, 0, 0);
        run_pass(2, $urandom_range(0, 255), 1, 0, 0);

        // Abort in cycle 10 (coinciding with a transfer), then a clean restart.
        run_pass(0, 0, 0, 10, 0);
        run_pass(0, 7, 0, 0, 0);
        run_pass(1, $urandom_range(0, 65535), 1, $urandom_range(2, 40), 0);
        run_pass(1, 3, 0, 0, 0);

        // start while busy must not disturb the sequence.
        run_pass(0, $urandom_range(0, 65535), 1, 0, 1);

        // Synchronous reset in the middle of a pass.
        sel     = 0;
        g_base  = 16'd5;
        g_start = 1'b1;
        @(negedge clk);
        g_start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_idle("midreset");
        chk("midreset_addr",  64'(m_addr),  0);
        chk("midreset_idx",   64'(m_idx),   0);
        chk("midreset_first", 64'(m_first), 0);
        chk("midreset_last",  64'(m_last),  0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("midreset_release");
        run_pass(0, 0, 0, 0, 0);

        // Randomized passes across all configurations.
        for (int i = 0; i < 6; i++) begin
            int s;
            s = $urandom_range(0, 2);
            run_pass(s, (s == 2) ? $urandom_range(0, 255) : $urandom_range(0, 65535),
                     $urandom_range(0, 1), 0, $urandom_range(0, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
